regfile_trace_buffer: RTL

Hardware capture unit that snoops the pipeline's register-file write-back port and stores selected writes in an on-chip trace FIFO, tagged with a cycle stamp. It sits beside the register file in `top` and replaces fixed, hard-coded register dumps with a parametrised watch set, bounded depth, overflow accounting and hardware halt detection (PC match or cycle limit). A bench or debug port drains entries over a valid/ready interface.

---
 rtl/trace_pkg.sv | 31 +++
 rtl/trace_fifo.sv | 66 ++++++
 rtl/regfile_trace_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and defaults for the register-file trace buffer.
package trace_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned CYC_W_DEF  = 16;

  // Capture/halt controller state.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } trace_state_e;

  // Trace entry at the default widths; the top level re-declares the same
  // layout locally so it follows its own parameter overrides.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic [CYC_W_DEF-1:0]  cycle;
  } trace_entry_t;

  // Packed width of one trace entry for a given set of field widths.
  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned data_w,
                                              input int unsigned cyc_w);
    return addr_w + data_w + cyc_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only when a pop happens in the same cycle; a pop while empty is ignored.
module trace_fifo #(
  parameter int unsigned WIDTH = 53,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Head is forced to zero when empty so the outputs are defined out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2**n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/regfile_trace_buffer.sv
// Snoops register-file write-back, filters by a watch mask, and stores
// cycle-stamped entries in a trace FIFO. Halts capture on a PC match or a
// cycle limit; restart resumes and clears the counters.
module regfile_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CYC_W  = CYC_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [PC_W-1:0]        pc_if,
  input  logic [2**ADDR_W-1:0]   watch_mask,
  input  logic [PC_W-1:0]        halt_pc,
  input  logic                   halt_pc_en,
  input  logic [CYC_W-1:0]       max_cycles,
  input  logic                   restart,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [CYC_W-1:0]       rd_cycle,
  output logic [$clog2(DEPTH):0] count,
  output logic [CYC_W-1:0]       drop_cnt,
  output logic [CYC_W-1:0]       cycle,
  output logic                   halted
);

  localparam int unsigned        ENTRY_W = entry_width(ADDR_W, DATA_W, CYC_W);
  localparam logic [CYC_W-1:0]   CYC_MAX = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  trace_state_e     state_q, state_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [CYC_W-1:0] drop_q, drop_d;

  logic   halt_cond;
  logic   capture;
  logic   pop;
  logic   drop_event;
  logic   fifo_full;
  logic   fifo_empty;
  entry_t wr_entry;
  entry_t rd_entry;

  assign halt_cond = (halt_pc_en && (pc_if == halt_pc)) ||
                     ((max_cycles != '0) && (cycle_q == max_cycles));

  // Register 0 is hard-wired zero, so writes to it are never traced.
  assign capture = (state_q == RUN) && wb_en && (wb_addr != '0) &&
                   watch_mask[wb_addr];

  assign pop        = !fifo_empty && rd_ready;
  assign drop_event = capture && fifo_full && !pop;

  // Stamp uses the pre-increment cycle value of the write-back cycle.
  assign wr_entry = '{addr: wb_addr, data: wb_data, cycle: cycle_q};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Controller next state; restart wins over a halt seen in the same cycle.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = RUN;
    end else if ((state_q == RUN) && halt_cond) begin
      state_d = HALTED;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Saturating cycle stamp (runs only in RUN) and drop counter.
  always_comb begin
    cycle_d = cycle_q;
    drop_d  = drop_q;
    if (restart) begin
      cycle_d = '0;
      drop_d  = '0;
    end else begin
      if ((state_q == RUN) && (cycle_q != CYC_MAX)) cycle_d = cycle_q + CYC_W'(1);
      if (drop_event && (drop_q != CYC_MAX))        drop_d  = drop_q + CYC_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  assign rd_valid = !fifo_empty;
  assign rd_addr  = rd_entry.addr;
  assign rd_data  = rd_entry.data;
  assign rd_cycle = rd_entry.cycle;
  assign drop_cnt = drop_q;
  assign cycle    = cycle_q;
  assign halted   = (state_q == HALTED);

endmodule
